// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: coin macros, FSM state encoding and coin value lookup shared by the change dispenser.
`ifndef kNumCoins
`define kNumCoins 3
`endif
`ifndef kCoin100
`define kCoin100 100
`endif
`ifndef kCoin500
`define kCoin500 500
`endif
`ifndef kCoin1000
`define kCoin1000 1000
`endif

package change_dispenser_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_DONE} state_e;

  function automatic logic [31:0] coin_value(input logic [`kNumCoins-1:0] c);
    return c[2] ? 32'(`kCoin1000) : c[1] ? 32'(`kCoin500) : c[0] ? 32'(`kCoin100) : 32'd0;
  endfunction
endpackage

// File: rtl/change_dispenser_coin_select.sv
// coin_select: picks the largest available denomination not exceeding the remaining balance (one-hot, 0 if none).
module coin_select
  import change_dispenser_pkg::*;
(
  input  logic [31:0]            remaining_i,
  input  logic [`kNumCoins-1:0]  avail_i,
  output logic [`kNumCoins-1:0]  coin_o
);
  always_comb
    coin_o = (avail_i[2] && remaining_i >= 32'(`kCoin1000)) ? 3'b100 :
             (avail_i[1] && remaining_i >= 32'(`kCoin500))  ? 3'b010 :
             (avail_i[0] && remaining_i >= 32'(`kCoin100))  ? 3'b001 : 3'b000;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: refunds a balance one coin per transfer via an IDLE/DISPENSE/DONE FSM.
// Optional per-denomination stock tracking is enabled by defining COIN_INVENTORY_EN.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int P_STOCK_1000 = 8,
  parameter int P_STOCK_500  = 8,
  parameter int P_STOCK_100  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_start,
  input  logic [31:0]            i_balance,
  input  logic                   i_coin_ready,
  output logic [`kNumCoins-1:0]  o_return_coin,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [31:0]            o_remaining,
  output logic                   o_residue
);
  state_e                 state_q;
  logic [31:0]            rem_q;
  logic                   residue_q;
  logic [`kNumCoins-1:0]  avail;
  logic [`kNumCoins-1:0]  sel;
  logic                   xfer;

  coin_select u_sel (.remaining_i(rem_q), .avail_i(avail), .coin_o(sel));

  assign xfer          = (state_q == S_DISPENSE) && (sel != '0) && i_coin_ready;
  assign o_return_coin = (state_q == S_DISPENSE) ? sel : '0;
  assign o_busy        = state_q != S_IDLE;
  assign o_done        = state_q == S_DONE;
  assign o_remaining   = rem_q;
  assign o_residue     = residue_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      residue_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:
          if (i_start) begin
            rem_q     <= i_balance;
            residue_q <= 1'b0;
            state_q   <= S_DISPENSE;
          end
        S_DISPENSE:
          if (sel == '0) begin
            residue_q <= rem_q != '0;
            state_q   <= S_DONE;
          end else if (i_coin_ready) begin
            rem_q <= rem_q - coin_value(sel);
          end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end

`ifdef COIN_INVENTORY_EN
  logic [15:0] stock_q [`kNumCoins];

  for (genvar i = 0; i < `kNumCoins; i++) begin : g_avail
    assign avail[i] = stock_q[i] != '0;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stock_q[0] <= 16'(P_STOCK_100);
      stock_q[1] <= 16'(P_STOCK_500);
      stock_q[2] <= 16'(P_STOCK_1000);
    end else if (xfer) begin
      for (int i = 0; i < `kNumCoins; i++)
        if (sel[i]) stock_q[i] <= stock_q[i] - 16'd1;
    end
`else
  logic unused_stock;
  assign avail        = '1;
  assign unused_stock = |{32'(P_STOCK_1000), 32'(P_STOCK_500), 32'(P_STOCK_100), 31'd0, xfer};
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed checks of refund sequencing, stalls, residue, zero balance and async reset.
module tb_change_dispenser;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_balance = '0;
  logic        i_coin_ready = 1'b0;
  logic [2:0]  o_return_coin;
  logic        o_busy, o_done, o_residue;
  logic [31:0] o_remaining;
  int n_chk = 0;
  int n_pass = 0;

  change_dispenser #(.P_STOCK_1000(1), .P_STOCK_500(8), .P_STOCK_100(16)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_balance(i_balance),
    .i_coin_ready(i_coin_ready), .o_return_coin(o_return_coin), .o_busy(o_busy),
    .o_done(o_done), .o_remaining(o_remaining), .o_residue(o_residue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_coin"}, 32'(o_return_coin), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_rem"}, o_remaining, 0);
    chk({tag, "_res"}, 32'(o_residue), 0);
  endtask

  task automatic do_reset();
    i_start = 1'b0;
    reset_n = 1'b0;
    #2;
    chk_idle("reset");
    reset_n = 1'b1;
    #1;
  endtask

  task automatic start(input logic [31:0] bal);
    i_balance = bal;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  initial begin
    #3;
    chk_idle("por");
    step();
    do_reset();
    i_coin_ready = 1'b1;
    start(2000);
    chk("s2000_coin0", 32'(o_return_coin), 4);
    chk("s2000_busy", 32'(o_busy), 1);
    step();
    chk("s2000_rem1", o_remaining, 1000);
`ifdef COIN_INVENTORY_EN
    chk("s2000_coin1", 32'(o_return_coin), 2);
    step();
    chk("s2000_rem2", o_remaining, 500);
    chk("s2000_coin2", 32'(o_return_coin), 2);
    step();
`else
    chk("s2000_coin1", 32'(o_return_coin), 4);
    step();
`endif
    chk("s2000_rem_end", o_remaining, 0);
    chk("s2000_coin_end", 32'(o_return_coin), 0);
    step();
    chk("s2000_done", 32'(o_done), 1);
    chk("s2000_res", 32'(o_residue), 0);
    step();
    do_reset();
    start(1600);
    chk("s1600_coin0", 32'(o_return_coin), 4);
    chk("s1600_rem0", o_remaining, 1600);
    step();
    chk("s1600_coin1", 32'(o_return_coin), 2);
    chk("s1600_rem1", o_remaining, 600);
    step();
    chk("s1600_coin2", 32'(o_return_coin), 1);
    chk("s1600_rem2", o_remaining, 100);
    step();
    chk("s1600_coin3", 32'(o_return_coin), 0);
    chk("s1600_done_early", 32'(o_done), 0);
    step();
    chk("s1600_done", 32'(o_done), 1);
    chk("s1600_rem", o_remaining, 0);
    chk("s1600_res", 32'(o_residue), 0);
    step();
    chk("s1600_idle_done", 32'(o_done), 0);
    chk("s1600_idle_busy", 32'(o_busy), 0);
    do_reset();
    i_coin_ready = 1'b0;
    start(1000);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_coin", k), 32'(o_return_coin), 4);
      chk($sformatf("stall%0d_rem", k), o_remaining, 1000);
      if (k < 4) step();
    end
    i_coin_ready = 1'b1;
    step();
    chk("stall_xfer_rem", o_remaining, 0);
    chk("stall_xfer_coin", 32'(o_return_coin), 0);
    step();
    chk("stall_done", 32'(o_done), 1);
    step();
    start(250);
    chk("s250_coin0", 32'(o_return_coin), 1);
    step();
    chk("s250_rem1", o_remaining, 150);
    chk("s250_coin1", 32'(o_return_coin), 1);
    step();
    chk("s250_rem2", o_remaining, 50);
    chk("s250_coin2", 32'(o_return_coin), 0);
    step();
    chk("s250_done", 32'(o_done), 1);
    chk("s250_rem", o_remaining, 50);
    chk("s250_res", 32'(o_residue), 1);
    step();
    i_balance = 0;
    i_start = 1'b1;
    step();
    chk("s0_busy", 32'(o_busy), 1);
    chk("s0_coin", 32'(o_return_coin), 0);
    chk("s0_done_early", 32'(o_done), 0);
    chk("s0_res_clr", 32'(o_residue), 0);
    i_balance = 900;
    step();
    chk("s0_done", 32'(o_done), 1);
    chk("s0_rem", o_remaining, 0);
    step();
    i_start = 1'b0;
    chk("s0_ignored_busy", 32'(o_busy), 0);
    chk("s0_ignored_rem", o_remaining, 0);
    step();
    chk("s0_still_idle", 32'(o_busy), 0);
    start(3000);
    step();
    chk("s3000_rem", o_remaining, 2000);
    chk("s3000_coin", 32'(o_return_coin), 4);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("async_rst");
    step();
    reset_n = 1'b1;
    step();
    chk_idle("post_rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
